// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the unified-memory arbiter.
//   state_t  : arbiter FSM state encoding
//   owner_t  : which requester owns the current access
//   MEM_LAT_DEF : default number of cycles the memory bus is held per access
package mem_arbiter_pkg;

    localparam int MEM_LAT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-bus signals of the arbiter.
//   I-side : i_req, i_addr -> i_rdata, i_ack
//   D-side : d_req, d_wr, d_addr, d_wdata -> d_rdata, d_ack
//   Memory : mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata
//   Status : busy
// slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: 4-bit access-cycle counter.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : force count to 0
//   i_en     : advance count by one
//   o_term   : count has reached MEM_LAT-1 (final access cycle)
// MEM_LAT legal range is 1..15 so MEM_LAT-1 always fits in 4 bits.
module mem_wait_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 4'd1;
    end

    assign o_term = (r_cnt == 4'(MEM_LAT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between the
// instruction-fetch side (read only) and the data side (load/store).
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (requester handshakes, memory bus, busy)
// Each access: grant in IDLE, hold the bus MEM_LAT cycles in ACCESS, then a
// one-cycle ack in DONE. Contention alternates between the two sides.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_t            r_state;
    owner_t            r_owner;
    owner_t            r_last;
    logic              w_term;
    logic              w_grant_d;
    owner_t            w_own;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // D wins when it is alone, or on contention when I was served last.
    assign w_grant_d = bus.d_req & (~bus.i_req | (r_last == OWN_I));
    assign w_own     = w_grant_d ? OWN_D : OWN_I;
    assign w_addr    = w_grant_d ? bus.d_addr : bus.i_addr;
    assign w_wdata   = w_grant_d ? bus.d_wdata : '0;

    // Held at zero throughout IDLE so it starts from 0 on the first ACCESS cycle.
    mem_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state == IDLE),
        .i_en   (r_state == ACCESS),
        .o_term (w_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= OWN_I;
            r_last        <= OWN_I;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        r_owner       <= w_own;
                        r_last        <= w_own;
                        bus.mem_en    <= 1'b1;
                        bus.mem_wr    <= w_grant_d & bus.d_wr;
                        bus.mem_addr  <= w_addr;
                        bus.mem_wdata <= w_wdata;
                        bus.busy      <= 1'b1;
                        r_state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_term) begin
                        // mem_wr still holds the latched direction here.
                        if (!bus.mem_wr) begin
                            if (r_owner == OWN_D) bus.d_rdata <= bus.mem_rdata;
                            else                  bus.i_rdata <= bus.mem_rdata;
                        end
                        if (r_owner == OWN_D) bus.d_ack <= 1'b1;
                        else                  bus.i_ack <= 1'b1;
                        bus.mem_en <= 1'b0;
                        bus.mem_wr <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_wr <= 1'b0;
                    bus.busy   <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (MEM_LAT=4 and MEM_LAT=1), each driven by a
// directed prefix plus random traffic and compared every cycle against a
// grant-schedule reference model.
module tb_mem_arbiter;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;
    bit   done [2];

    typedef struct {
        bit          rst;
        bit          ir;
        logic [15:0] ia;
        bit          dr;
        bit          dw;
        logic [15:0] da;
        logic [15:0] dd;
    } stim_t;

    function automatic stim_t mk(input bit rst, input bit ir, input logic [15:0] ia,
                                 input bit dr, input bit dw, input logic [15:0] da,
                                 input logic [15:0] dd);
        stim_t s;
        s.rst = rst; s.ir = ir; s.ia = ia; s.dr = dr; s.dw = dw; s.da = da; s.dd = dd;
        return s;
    endfunction

    // Power-up memory contents; address 0x10 holds 0xA5A5.
    function automatic logic [15:0] fill(input logic [7:0] a);
        return (a == 8'h10) ? 16'hA5A5 : ({a, ~a} ^ 16'h3C3C);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 4 : 1;

        logic rst;
        mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

        mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Fixed-latency memory: data is only valid in the L-th consecutive
        // enabled cycle; earlier cycles return the inverted word.
        logic [15:0] tmem [256];
        bit          tval [256];
        int          run;
        logic [15:0] rd_word;

        always_comb rd_word = tval[bus.mem_addr[7:0]] ? tmem[bus.mem_addr[7:0]]
                                                      : fill(bus.mem_addr[7:0]);
        assign bus.mem_rdata = (bus.mem_en && run == L - 1) ? rd_word : ~rd_word;

        always @(posedge clk) begin
            run <= bus.mem_en ? run + 1 : 0;
            if (bus.mem_en && bus.mem_wr) begin
                tmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
                tval[bus.mem_addr[7:0]] <= 1'b1;
            end
        end

        initial begin
            stim_t       q[$];
            logic [15:0] mm [256];
            bit          have_g, own, lwr, last_d, chk_on, en, ack, bsy, pick_d;
            int          g, free_at;
            logic [15:0] la, lwd, eird, edrd;

            rst = 1'b1;
            bus.i_req = 1'b0; bus.i_addr = '0;
            bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

            repeat (2) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
            if (gi == 0) begin
                // Both sides held high: D, I, D, I.
                repeat (24) q.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 0));
                repeat (2)  q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                // Single I read of 0x0010.
                q.push_back(mk(0, 1, 16'h0010, 0, 0, 0, 0));
                repeat (7)  q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                // D store 0x1234 -> 0x0200.
                q.push_back(mk(0, 0, 0, 1, 1, 16'h0200, 16'h1234));
                repeat (7)  q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                // D load of 0x0300 with the address changing mid-access.
                repeat (2)  q.push_back(mk(0, 0, 0, 1, 0, 16'h0300, 0));
                repeat (4)  q.push_back(mk(0, 0, 0, 0, 0, 16'h0400, 16'hFFFF));
                repeat (3)  q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                // Reset in cycle 2 of an access, then contention.
                q.push_back(mk(0, 1, 16'h0040, 0, 0, 0, 0));
                q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                q.push_back(mk(0, 1, 16'h0050, 1, 0, 16'h0060, 0));
                repeat (7)  q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            end else begin
                // Back-to-back I reads.
                for (int k = 0; k < 9; k++) q.push_back(mk(0, 1, 16'(16'h0010 + k), 0, 0, 0, 0));
                repeat (3) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            end
            for (int k = 0; k < 1500; k++)
                q.push_back(mk($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                               16'($urandom) & 16'hFF0F, $urandom_range(0, 2) == 0,
                               1'($urandom), 16'($urandom) & 16'hFF0F, 16'($urandom)));

            for (int i = 0; i < 256; i++) mm[i] = fill(8'(i));
            have_g = 0; own = 0; lwr = 0; last_d = 0; chk_on = 0;
            g = 0; free_at = 0; la = '0; lwd = '0; eird = '0; edrd = '0;

            for (int c = 0; c < q.size(); c++) begin
                @(posedge clk); #1;
                rst         = q[c].rst;
                bus.i_req   = q[c].ir;
                bus.i_addr  = q[c].ia;
                bus.d_req   = q[c].dr;
                bus.d_wr    = q[c].dw;
                bus.d_addr  = q[c].da;
                bus.d_wdata = q[c].dd;
                @(negedge clk);

                if (chk_on) begin
                    en  = have_g && c >= g + 1 && c <= g + L;
                    ack = have_g && c == g + L + 1;
                    bsy = have_g && c >= g + 1 && c <= g + L + 1;
                    if (ack && !lwr) begin
                        if (own) edrd = mm[la[7:0]];
                        else     eird = mm[la[7:0]];
                    end
                    chk($sformatf("L%0d c%0d mem_en", L, c), bus.mem_en, en);
                    chk($sformatf("L%0d c%0d mem_wr", L, c), bus.mem_wr, en && lwr);
                    chk($sformatf("L%0d c%0d i_ack", L, c), bus.i_ack, ack && !own);
                    chk($sformatf("L%0d c%0d d_ack", L, c), bus.d_ack, ack && own);
                    chk($sformatf("L%0d c%0d busy", L, c), bus.busy, bsy);
                    chk($sformatf("L%0d c%0d i_rdata", L, c), bus.i_rdata, eird);
                    chk($sformatf("L%0d c%0d d_rdata", L, c), bus.d_rdata, edrd);
                    if (!have_g) begin
                        chk($sformatf("L%0d c%0d mem_addr", L, c), bus.mem_addr, 16'h0);
                        chk($sformatf("L%0d c%0d mem_wdata", L, c), bus.mem_wdata, 16'h0);
                    end else if (en) begin
                        chk($sformatf("L%0d c%0d mem_addr", L, c), bus.mem_addr, la);
                        if (lwr) chk($sformatf("L%0d c%0d mem_wdata", L, c), bus.mem_wdata, lwd);
                    end
                end

                if (q[c].rst) begin
                    have_g = 0; free_at = c + 1; last_d = 0;
                    eird = '0; edrd = '0; chk_on = 1;
                end else if (c >= free_at && (q[c].ir || q[c].dr)) begin
                    pick_d  = q[c].dr && (!q[c].ir || !last_d);
                    have_g  = 1;
                    g       = c;
                    own     = pick_d;
                    la      = pick_d ? q[c].da : q[c].ia;
                    lwd     = q[c].dd;
                    lwr     = pick_d && q[c].dw;
                    last_d  = pick_d;
                    free_at = c + L + 2;
                    // The memory takes the store on the first access cycle.
                    if (lwr) mm[la[7:0]] = lwd;
                end
            end
            done[gi] = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 20000; k++) begin
            if (done[0] && done[1]) break;
            @(posedge clk);
        end
        chk("run_complete", {31'b0, done[0] & done[1]}, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between instruction fetch (I-side, read-only) and the data path (D-side, LW/SW).
- D-side requests come from the decoded MemRead/MemWrite/SW controls.
- Sequences each access through a multi-cycle memory: latches the request, holds the memory bus stable for MEM_LAT cycles, then returns data with a one-cycle ack.
- Two-way alternating priority on contention prevents starvation of either side.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 4, cycles the memory bus must be held per access; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request, level
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse, I-side
- d_req  in  1  data request, level (MemRead|MemWrite)
- d_wr  in  1  1=store (SW), 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse, D-side
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in final access cycle
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (synchronous, active-high; clk and rst only):
  - State goes to IDLE.
  - All outputs clear to 0: mem_*, i_/d_ack, i_/d_rdata, busy.
  - last_grant resets to I.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant that side.
- IDLE, both requests: grant the side not granted last (alternation). After reset the first contention goes to D.
- On grant (edge leaving IDLE):
  - Latch owner, addr, wdata and wr; I-side forces wr=0.
  - Update last_grant; clear wait counter; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_wr, mem_addr and mem_wdata hold the latched values, stable for exactly MEM_LAT cycles.
  - Counter counts 0..MEM_LAT-1.
  - At count MEM_LAT-1, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - mem_en=0, mem_wr=0.
  - Owner's ack=1 for exactly this cycle; rdata valid.
  - Go to IDLE unconditionally; requests are not sampled in DONE.
- Timing: request high in IDLE at cycle 0 → mem_en high in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1. The next grant can occur no earlier than cycle MEM_LAT+2.
- Stores: d_ack still pulses; d_rdata keeps its previous value.
- rdata registers hold their value between acks.
- Requester inputs are sampled only at grant. Changes to addr/wdata/wr or deassertion of req during ACCESS/DONE are ignored; the access is never aborted.
- Requester protocol: req must be low by the cycle after ack unless a new access is wanted. A req still high in IDLE is a new request.
- MEM_LAT=1: ACCESS lasts one cycle; capture and the ACCESS→DONE transition happen in that cycle.
- Reset mid-access (ACCESS or DONE): abort immediately at that edge; no ack is issued; the in-flight request is lost and the requester must reissue it.
- A request asserted the same cycle another side receives ack is served in a later IDLE, per alternation.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Owner encoding: OWN_I=1'b0, OWN_D=1'b1.
  - MEM_LAT default constant.
- Sub-module mem_wait_cnt: 4-bit counter with clear/enable and a terminal flag at MEM_LAT-1.
- Arbitration and FSM live in mem_arbiter.

Test Plan:
- Single I read, MEM_LAT=4, i_addr=16'h0010, memory returns 16'hA5A5 → mem_en high cycles 1-4 with mem_addr=16'h0010 and mem_wr=0; i_ack=1 with i_rdata=16'hA5A5 in cycle 5 only; busy low again in cycle 6.
- D store d_addr=16'h0200, d_wdata=16'h1234 → mem_wr=1, mem_wdata=16'h1234 for 4 cycles; d_ack pulse in cycle 5; d_rdata unchanged.
- i_req and d_req held high continuously after reset → grants alternate D, I, D, I; acks at cycles 5, 11, 17, 23.
- d_addr changed from 16'h0300 to 16'h0400 in cycle 2 of a load → mem_addr stays 16'h0300 for all access cycles.
- rst asserted in cycle 2 of an access → cycle 3 shows mem_en=0, busy=0, no ack; a request after reset goes to D on contention.
- MEM_LAT=1 build, back-to-back I reads → mem_en for 1 cycle, ack 2 cycles after request, next grant 3 cycles after the first.
